// File: rtl/batcharger_ctrl_gen2.sv
// ---------------------------------------------------------------------------
// batcharger_ctrl_gen2
//   Li-ion charge controller: trickle / constant-current / constant-voltage /
//   end-of-charge / latched fault. Sits between the ADC/OTP interfaces and the
//   analog POWER block.
//
//   Optional feature macro: BATCHG_TC_TIMEOUT_EN
//     defined   -> parameter TCMAX and a trickle-dwell timer (candidate FAULT
//                  once TC dwell >= TCMAX timer units)
//     undefined -> trickle dwell is unbounded, no TC timer logic
//
// Ports
//   clk, rstz          clock, async active-low reset
//   en, vtok           enable, ADC sample valid (qualifier Cs = en & vtok)
//   vbat, ibat, tbat   ADC codes (W bits)
//   vcutoff, vpreset, vrecharge, tempmin, tempmax, iend   OTP thresholds (W)
//   tmax               OTP max CC+CV time, in 2^DIVB-cycle units (TW)
//   fault_clr          one-cycle pulse, leaves FAULT
//   cc, tc, cv         POWER block mode selects
//   imonen, vmonen, tmonen  monitor enables
//   fault              high in FAULT
//   state_o            state code
//   dvdd, dgnd         supply pins, pass-through only
// ---------------------------------------------------------------------------
module batcharger_ctrl_gen2 #(
  parameter int W    = 8,
  parameter int TW   = 8,
  parameter int DIVB = 8,
  parameter int DEB  = 4,
  parameter int VMAX = 214
`ifdef BATCHG_TC_TIMEOUT_EN
  ,
  parameter int TCMAX = 64
`endif
) (
  input  logic          clk,
  input  logic          rstz,
  input  logic          en,
  input  logic          vtok,
  input  logic [W-1:0]  vbat,
  input  logic [W-1:0]  ibat,
  input  logic [W-1:0]  tbat,
  input  logic [W-1:0]  vcutoff,
  input  logic [W-1:0]  vpreset,
  input  logic [W-1:0]  vrecharge,
  input  logic [W-1:0]  tempmin,
  input  logic [W-1:0]  tempmax,
  input  logic [TW-1:0] tmax,
  input  logic [W-1:0]  iend,
  input  logic          fault_clr,
  output logic          cc,
  output logic          tc,
  output logic          cv,
  output logic          imonen,
  output logic          vmonen,
  output logic          tmonen,
  output logic          fault,
  output logic [2:0]    state_o,
  inout  wire           dvdd,
  inout  wire           dgnd
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TC    = 3'd1,
    S_CC    = 3'd2,
    S_CV    = 3'd3,
    S_ENDC  = 3'd4,
    S_FAULT = 3'd5
  } st_t;

  // registered comparison results
  typedef struct packed {
    logic t;   // tempmin <= tbat <= tempmax
    logic hi;  // vbat >= VMAX
    logic lo;  // vbat <  vcutoff
    logic pr;  // vbat >= vpreset
    logic rc;  // vbat <= vrecharge
    logic ie;  // ibat <  iend
    logic to;  // ctime >= tmax
  } cond_t;

  localparam int DCW = $clog2(DEB + 1);

  st_t             state, cand, nxt, deb_cand;
  cond_t           cnd;
  logic [DCW-1:0]  deb_cnt, deb_inc;
  logic            cs, deb_hit, go;
  logic [DIVB-1:0] presc;
  logic [TW-1:0]   ctime;
  logic            presc_run, presc_clr;

  // supply pins carry no logic
  wire unused_ok = &{1'b0, dvdd, dgnd};

  assign cs      = en & vtok;
  assign state_o = state;

  // ---- condition registers (one clock of latency) -------------------------
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      cnd <= '0;
    end else begin
      cnd.t  <= (tbat >= tempmin) && (tbat <= tempmax);
      cnd.hi <= vbat >= W'(VMAX);
      cnd.lo <= vbat <  vcutoff;
      cnd.pr <= vbat >= vpreset;
      cnd.rc <= vbat <= vrecharge;
      cnd.ie <= ibat <  iend;
      cnd.to <= ctime >= tmax;
    end
  end

`ifdef BATCHG_TC_TIMEOUT_EN
  logic [TW-1:0] tctime;
  logic          tco;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      tctime <= '0;
      tco    <= 1'b0;
    end else begin
      if (state != S_TC)                    tctime <= '0;
      else if (&presc && !(&tctime))        tctime <= tctime + 1'b1;
      tco <= tctime >= TW'(TCMAX);
    end
  end
`endif

  // ---- candidate next state ----------------------------------------------
  always_comb begin
    cand = state;
    case (state)
      S_IDLE: begin
        if (!cnd.t)      cand = S_IDLE;
        else if (cnd.hi) cand = S_ENDC;
        else if (cnd.rc) cand = cnd.lo ? S_TC : S_CC;
      end
      S_TC: begin
        if (!cnd.t)      cand = S_IDLE;
`ifdef BATCHG_TC_TIMEOUT_EN
        else if (tco)    cand = S_FAULT;
`endif
        else if (!cnd.lo) cand = S_CC;
      end
      S_CC: begin
        if (!cnd.t)      cand = S_IDLE;
        else if (cnd.to) cand = S_FAULT;
        else if (cnd.pr) cand = S_CV;
      end
      S_CV: begin
        if (!cnd.t)               cand = S_IDLE;
        else if (cnd.to || cnd.ie) cand = S_ENDC;
      end
      S_ENDC: begin
        if (cnd.rc)      cand = S_IDLE;
      end
      default: cand = state;
    endcase
  end

  // ---- debounce + forced exits -------------------------------------------
  // deb_cnt counts consecutive clocks the same candidate has been seen;
  // a nonzero count with a different candidate restarts at 1.
  always_comb begin
    deb_hit = (cand == deb_cand) && (deb_cnt != '0);
    deb_inc = deb_hit ? deb_cnt + 1'b1 : DCW'(1);
    go      = (cand != state) && (deb_inc >= DCW'(DEB));

    nxt = state;
    if (state == S_FAULT) begin
      if (!en || fault_clr) nxt = S_IDLE;
    end else if (!cs || (state > S_FAULT)) begin
      nxt = S_IDLE;
    end else if (go) begin
      nxt = cand;
    end
  end

  // {cc, tc, cv, imonen, vmonen, tmonen, fault}
  function automatic logic [6:0] dec(input st_t s);
    case (s)
      S_TC:    dec = 7'b0100110;
      S_CC:    dec = 7'b1000110;
      S_CV:    dec = 7'b0011010;
      S_ENDC:  dec = 7'b0000100;
      S_FAULT: dec = 7'b0000001;
      default: dec = 7'b0000110;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state    <= S_IDLE;
      deb_cand <= S_IDLE;
      deb_cnt  <= '0;
      {cc, tc, cv, imonen, vmonen, tmonen, fault} <= 7'b0000110;
    end else begin
      state <= nxt;
      {cc, tc, cv, imonen, vmonen, tmonen, fault} <= dec(nxt);
      // count only while a qualified, still-pending candidate is held
      if (!cs || (nxt != state) || (cand == state)) begin
        deb_cnt <= '0;
      end else begin
        deb_cnt  <= deb_inc;
        deb_cand <= cand;
      end
    end
  end

  // ---- charge timer ------------------------------------------------------
  always_comb begin
`ifdef BATCHG_TC_TIMEOUT_EN
    // prescaler also paces the TC dwell timer; restart it when TC is left
    presc_run = (state == S_TC) || (state == S_CC) || (state == S_CV);
    presc_clr = (state == S_IDLE) || ((state == S_TC) && (nxt != S_TC));
`else
    presc_run = (state == S_CC) || (state == S_CV);
    presc_clr = (state == S_IDLE) || (state == S_TC);
`endif
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      presc <= '0;
      ctime <= '0;
    end else begin
      if (presc_clr)      presc <= '0;
      else if (presc_run) presc <= presc + 1'b1;

      if ((state == S_IDLE) || (state == S_TC))
        ctime <= '0;
      else if (((state == S_CC) || (state == S_CV)) && (&presc) && !(&ctime))
        ctime <= ctime + 1'b1;  // saturates at all-ones
    end
  end

endmodule

// File: tb/tb_batcharger_ctrl_gen2.sv
module tb_batcharger_ctrl_gen2;

  localparam int DEB = 4;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_TC = 3'd1, ST_CC = 3'd2,
                         ST_CV = 3'd3, ST_ENDC = 3'd4, ST_FLT = 3'd5;
  // {cc, tc, cv, imonen, vmonen, tmonen, fault}
  localparam logic [6:0] O_IDLE = 7'b0000110, O_TC = 7'b0100110,
                         O_CC = 7'b1000110, O_CV = 7'b0011010,
                         O_ENDC = 7'b0000100, O_FLT = 7'b0000001;

  logic       clk = 1'b0, rstz = 1'b0, en = 1'b0, vtok = 1'b0, fault_clr = 1'b0;
  logic [7:0] vbat = 8'd0, ibat = 8'd50, tbat = 8'd100;
  logic [7:0] vcutoff = 8'd147, vpreset = 8'd188, vrecharge = 8'd213;
  logic [7:0] tempmin = 8'd20, tempmax = 8'd200, iend = 8'd2, tmax = 8'd200;
  logic       cc, tc, cv, imonen, vmonen, tmonen, fault;
  logic [2:0] state_o;
  wire        dvdd, dgnd;
  assign dvdd = 1'b1;
  assign dgnd = 1'b0;

  wire [6:0] outs = {cc, tc, cv, imonen, vmonen, tmonen, fault};

  batcharger_ctrl_gen2 #(
    .W(8), .TW(8), .DIVB(8), .DEB(DEB), .VMAX(214)
`ifdef BATCHG_TC_TIMEOUT_EN
    , .TCMAX(1)
`endif
  ) dut (
    .clk(clk), .rstz(rstz), .en(en), .vtok(vtok),
    .vbat(vbat), .ibat(ibat), .tbat(tbat),
    .vcutoff(vcutoff), .vpreset(vpreset), .vrecharge(vrecharge),
    .tempmin(tempmin), .tempmax(tempmax), .tmax(tmax), .iend(iend),
    .fault_clr(fault_clr),
    .cc(cc), .tc(tc), .cv(cv), .imonen(imonen), .vmonen(vmonen),
    .tmonen(tmonen), .fault(fault), .state_o(state_o),
    .dvdd(dvdd), .dgnd(dgnd)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  typedef struct {
    string      nm;
    logic       en, vtok;
    logic [7:0] vbat, ibat, tbat;
    int         n;
    logic [2:0] st;
    logic [6:0] o;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string nm, input logic e, input logic v,
                              input int vb, input int ib, input int tb, input int n,
                              input logic [2:0] st, input logic [6:0] o);
    vec_t x;
    x.nm = nm; x.en = e; x.vtok = v;
    x.vbat = 8'(vb); x.ibat = 8'(ib); x.tbat = 8'(tb);
    x.n = n; x.st = st; x.o = o;
    tbl.push_back(x);
  endfunction

  // wait (bounded) at negedges until state_o == target
  task automatic wait_state(input string nm, input logic [2:0] target, input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      @(negedge clk);
      if (state_o == target) break;
    end
    chk(nm, state_o, target);
  endtask

  // negedges from now until state_o == target (bound returned on timeout)
  task automatic count_to(input logic [2:0] target, input int bound, output int k);
    k = 0;
    while (k < bound) begin
      @(negedge clk);
      k++;
      if (state_o == target) break;
    end
  endtask

  int k;

  initial begin
    // table: inputs held for n clocks, then state and outputs compared
    add("tc_wait",    1, 1, 100, 50, 100, DEB,   ST_IDLE, O_IDLE);
    add("tc_enter",   1, 1, 100, 50, 100, 1,     ST_TC,   O_TC);
    add("glitch",     1, 1, 150, 50, 100, DEB-1, ST_TC,   O_TC);
    add("glitch_end", 1, 1, 100, 50, 100, 2,     ST_TC,   O_TC);
    add("cc_wait",    1, 1, 150, 50, 100, DEB,   ST_TC,   O_TC);
    add("cc_enter",   1, 1, 150, 50, 100, 1,     ST_CC,   O_CC);
    add("cv_wait",    1, 1, 188, 50, 100, DEB,   ST_CC,   O_CC);
    add("cv_enter",   1, 1, 188, 50, 100, 1,     ST_CV,   O_CV);
    add("endc",       1, 1, 214, 1,  100, 5,     ST_ENDC, O_ENDC);
    add("endc_hold",  1, 1, 214, 1,  100, 10,    ST_ENDC, O_ENDC);
    add("rc_wait",    1, 1, 213, 1,  100, DEB,   ST_ENDC, O_ENDC);
    add("recharge",   1, 1, 213, 1,  100, 1,     ST_IDLE, O_IDLE);
    add("idle_to_cc", 1, 1, 150, 50, 100, DEB,   ST_CC,   O_CC);
    add("vtok_drop",  1, 0, 150, 50, 100, 1,     ST_IDLE, O_IDLE);
    add("idle_hi",    1, 1, 214, 50, 100, 5,     ST_ENDC, O_ENDC);
    add("endc_rc",    1, 1, 100, 50, 100, 5,     ST_IDLE, O_IDLE);
    add("cold",       1, 1, 100, 50, 10,  10,    ST_IDLE, O_IDLE);
    add("tmin_wait",  1, 1, 100, 50, 20,  DEB,   ST_IDLE, O_IDLE);
    add("tmin_edge",  1, 1, 100, 50, 20,  1,     ST_TC,   O_TC);
    add("hot",        1, 1, 100, 50, 201, 5,     ST_IDLE, O_IDLE);
    add("tmax_edge",  1, 1, 100, 50, 200, 5,     ST_TC,   O_TC);
    add("en_drop",    0, 1, 100, 50, 200, 1,     ST_IDLE, O_IDLE);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", state_o, ST_IDLE);
    chk("rst_outs",  outs,    O_IDLE);
    rstz = 1'b1;

    foreach (tbl[i]) begin
      en = tbl[i].en; vtok = tbl[i].vtok;
      vbat = tbl[i].vbat; ibat = tbl[i].ibat; tbat = tbl[i].tbat;
      repeat (tbl[i].n) @(posedge clk);
      @(negedge clk);
      chk({tbl[i].nm, "_st"}, state_o, tbl[i].st);
      chk({tbl[i].nm, "_o"},  outs,    tbl[i].o);
    end

    // CC timeout: tmax=2 -> ctime reaches 2 after 512 clks, +1 compare, +DEB
    tmax = 8'd2; tbat = 8'd100; ibat = 8'd50; vbat = 8'd150;
    en = 1'b1; vtok = 1'b1;
    wait_state("to_reach_cc", ST_CC, 50);
    count_to(ST_FLT, 2000, k);
    chk("to_cycles", k, 513 + DEB);
    chk("to_outs", outs, O_FLT);
    vtok = 1'b0;
    repeat (3) @(negedge clk);
    chk("flt_latched", state_o, ST_FLT);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("flt_clr", state_o, ST_IDLE);
    chk("flt_clr_o", outs, O_IDLE);

    // timer cleared by a one-clock vtok drop after ctime has advanced
    vtok = 1'b1;
    wait_state("ct_reach_cc", ST_CC, 50);
    repeat (300) @(negedge clk);
    chk("ct_hold_cc", state_o, ST_CC);
    vtok = 1'b0;
    @(negedge clk);
    chk("ct_drop", state_o, ST_IDLE);
    vtok = 1'b1;
    wait_state("ct_back_cc", ST_CC, 50);
    count_to(ST_FLT, 2000, k);
    chk("ct_cleared", k, 513 + DEB);
    en = 1'b0;
    @(negedge clk);
    chk("flt_en_exit", state_o, ST_IDLE);

    // vtok drop mid-CV
    tmax = 8'd200; vbat = 8'd188; en = 1'b1;
    wait_state("cvd_reach", ST_CV, 60);
    vtok = 1'b0;
    @(negedge clk);
    chk("cvd_idle", state_o, ST_IDLE);
    chk("cvd_o", outs, O_IDLE);

    // tmax=0: TO already true on CC entry, FAULT after DEB clks
    tmax = 8'd0; vbat = 8'd150; vtok = 1'b1;
    wait_state("t0_reach_cc", ST_CC, 50);
    count_to(ST_FLT, 100, k);
    chk("t0_cycles", k, DEB);
    en = 1'b0; fault_clr = 1'b1;
    @(negedge clk);
    en = 1'b1; fault_clr = 1'b0;
    chk("clr_and_en", state_o, ST_IDLE);

    // async reset mid-CC
    tmax = 8'd200;
    wait_state("ar_reach_cc", ST_CC, 50);
    #2 rstz = 1'b0;
    #1;
    chk("ar_state", state_o, ST_IDLE);
    chk("ar_outs", outs, O_IDLE);
    @(negedge clk);
    rstz = 1'b1;

`ifdef BATCHG_TC_TIMEOUT_EN
    // TC dwell: TCMAX=1 -> wrap at 256, +1 compare, +DEB
    vbat = 8'd50;
    wait_state("tct_reach_tc", ST_TC, 50);
    count_to(ST_FLT, 2000, k);
    chk("tct_cycles", k, 257 + DEB);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
